// File: rtl/riscv_muldiv_pkg.sv
// Shared types and operation-decode helpers for the RV32M multiply/divide unit.
package riscv_muldiv_pkg;

    // funct3 encodings of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // rs1 is interpreted as signed for these ops (MUL low half is sign-agnostic)
    function automatic logic is_signed_a(input muldiv_op_e op);
        logic r;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    // rs2 is interpreted as signed for these ops
    function automatic logic is_signed_b(input muldiv_op_e op);
        logic r;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    // DIV/DIVU/REM/REMU all have funct3[2] set
    function automatic logic is_div(input muldiv_op_e op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_muldiv_unit_divstep.sv
// One iteration of a restoring divider: shift {rem,quo} left by one, and
// subtract the divisor from the partial remainder when it fits.
module muldiv_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // Trial subtraction; the borrow bit tells whether the divisor fits
    always_comb begin
        shifted_s = {rem_i, quo_i[XLEN-1]};
        diff_s    = shifted_s - {1'b0, divisor_i};
        if (!diff_s[XLEN]) begin
            rem_o = diff_s[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted_s[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request/response.
// Optional build macro: RISCV_MULDIV_FAST_MUL_EN selects a single-cycle
// multiplier for MUL/MULH/MULHSU/MULHU; division stays iterative.
// Every operation passes through a finalize cycle (count==0) where the sign
// fix-up and result selection happen. Early-out cases (divide by zero,
// signed overflow) and the fast multiplier preload the accumulator with the
// answer and enter that finalize cycle immediately, giving one-edge latency.
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    muldiv_op_e        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   hi_q, hi_d;        // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;        // product low half / quotient
    logic              negq_q, negq_d;    // negate product or quotient
    logic              negr_q, negr_d;    // negate remainder
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_result_q, resp_result_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic              busy_q, busy_d;

    muldiv_op_e        req_op_s;
    logic              sign_a_s, sign_b_s, ovf_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic [XLEN-1:0]   step_rem_s, step_quo_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   mul_res_s, quo_fix_s, rem_fix_s, div_res_s;

    // Decode incoming request: signedness, magnitudes, overflow case
    always_comb begin
        req_op_s = muldiv_op_e'(req_op);
        sign_a_s = is_signed_a(req_op_s) & req_a[XLEN-1];
        sign_b_s = is_signed_b(req_op_s) & req_b[XLEN-1];
        mag_a_s  = sign_a_s ? (~req_a + ONE_X) : req_a;
        mag_b_s  = sign_b_s ? (~req_b + ONE_X) : req_b;
        ovf_s    = is_signed_a(req_op_s) & (req_a == MIN_X) & (req_b == ONES_X);
    end

    muldiv_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i     (hi_q),
        .quo_i     (lo_q),
        .divisor_i (opb_q),
        .rem_o     (step_rem_s),
        .quo_o     (step_quo_s)
    );

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;

    // Single-cycle magnitude product, loaded straight into the accumulator
    always_comb begin
        fast_prod_s = {ZERO_X, mag_a_s} * {ZERO_X, mag_b_s};
    end
`else
    logic [XLEN:0] mul_sum_s;

    // Shift-add step: add multiplicand to the high half when the LSB is set
    always_comb begin
        if (lo_q[0]) begin
            mul_sum_s = {1'b0, hi_q} + {1'b0, opb_q};
        end else begin
            mul_sum_s = {1'b0, hi_q};
        end
    end
`endif

    // Final-cycle sign fix-up and result selection from the accumulator
    always_comb begin
        prod_fix_s = negq_q ? (~{hi_q, lo_q} + ONE_2X) : {hi_q, lo_q};
        if (op_q == OP_MUL) begin
            mul_res_s = prod_fix_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_fix_s[2*XLEN-1:XLEN];
        end
        quo_fix_s = negq_q ? (~lo_q + ONE_X) : lo_q;
        rem_fix_s = negr_q ? (~hi_q + ONE_X) : hi_q;
        div_res_s = op_q[1] ? rem_fix_s : quo_fix_s;
    end

    // Next-state logic: FSM, counter, datapath registers and handshakes
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        op_d          = op_q;
        tag_d         = tag_q;
        opb_d         = opb_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        negq_d        = negq_q;
        negr_d        = negr_q;
        resp_result_d = resp_result_q;
        resp_tag_d    = resp_tag_q;

        if (flush) begin
            state_d = IDLE;
            count_d = {CW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_d   = req_op_s;
                        tag_d  = req_tag;
                        negr_d = 1'b0;
                        if (is_div(req_op_s)) begin
                            state_d = DIV;
                            if (req_b == ZERO_X) begin
                                // quotient all-ones, remainder = dividend
                                count_d = {CW{1'b0}};
                                hi_d    = req_a;
                                lo_d    = ONES_X;
                                negq_d  = 1'b0;
                            end else if (ovf_s) begin
                                // MIN / -1: quotient MIN, remainder 0
                                count_d = {CW{1'b0}};
                                hi_d    = ZERO_X;
                                lo_d    = MIN_X;
                                negq_d  = 1'b0;
                            end else begin
                                count_d = CW'(XLEN);
                                opb_d   = mag_b_s;
                                hi_d    = ZERO_X;
                                lo_d    = mag_a_s;
                                negq_d  = sign_a_s ^ sign_b_s;
                                negr_d  = sign_a_s;
                            end
                        end else begin
                            state_d = MUL;
                            negq_d  = sign_a_s ^ sign_b_s;
`ifdef RISCV_MULDIV_FAST_MUL_EN
                            count_d = {CW{1'b0}};
                            hi_d    = fast_prod_s[2*XLEN-1:XLEN];
                            lo_d    = fast_prod_s[XLEN-1:0];
`else
                            count_d = CW'(XLEN);
                            opb_d   = mag_a_s;
                            hi_d    = ZERO_X;
                            lo_d    = mag_b_s;
`endif
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                MUL: begin
                    if (count_q != {CW{1'b0}}) begin
`ifdef RISCV_MULDIV_FAST_MUL_EN
                        hi_d    = hi_q;
                        lo_d    = lo_q;
`else
                        hi_d    = mul_sum_s[XLEN:1];
                        lo_d    = {mul_sum_s[0], lo_q[XLEN-1:1]};
`endif
                        count_d = count_q - CW'(1);
                    end else begin
                        state_d       = DONE;
                        resp_result_d = mul_res_s;
                        resp_tag_d    = tag_q;
                    end
                end
                DIV: begin
                    if (count_q != {CW{1'b0}}) begin
                        hi_d    = step_rem_s;
                        lo_d    = step_quo_s;
                        count_d = count_q - CW'(1);
                    end else begin
                        state_d       = DONE;
                        resp_result_d = div_res_s;
                        resp_tag_d    = tag_q;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= {CW{1'b0}};
            op_q          <= OP_MUL;
            tag_q         <= {TAG_W{1'b0}};
            opb_q         <= ZERO_X;
            hi_q          <= ZERO_X;
            lo_q          <= ZERO_X;
            negq_q        <= 1'b0;
            negr_q        <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= ZERO_X;
            resp_tag_q    <= {TAG_W{1'b0}};
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            op_q          <= op_d;
            tag_q         <= tag_d;
            opb_q         <= opb_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            negq_q        <= negq_d;
            negr_q        <= negr_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_tag_q    <= resp_tag_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_tag    = resp_tag_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (XLEN=32, TAG_W=5), scoreboard based.
module tb_riscv_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, resp_ready;
    logic        req_ready, resp_valid, busy;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, resp_result;
    logic [4:0]  req_tag, resp_tag;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    riscv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference model built on 64-bit host arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sbu;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sbu = longint'(ub);
        case (op)
            3'd0: begin p = ua * ub;           return p[31:0];  end
            3'd1: begin p = 64'(sa * sb);      return p[63:32]; end
            3'd2: begin p = 64'(sa * sbu);     return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin if (b == 32'h0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
            3'd5: begin if (b == 32'h0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 32'h0) return a; p = 64'(sa % sb); return p[31:0]; end
            default: begin if (b == 32'h0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 32'h0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef RISCV_MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Issue one op, push expectation, wait for response, optionally stall resp_ready
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp_res, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check_val({nm, "_req_ready"}, {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        @(posedge clk);
        e.res = exp_res; e.tag = tag; e.lat = ref_lat(op, a, b);
        sb_q.push_back(e);
        #1;
        req_valid = 1'b0;
        check_val({nm, "_busy"}, {63'h0, busy}, 64'h1);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (resp_valid) break;
        end
        e = sb_q.pop_front();
        check_val({nm, "_latency"}, 64'(lat), 64'(e.lat));
        check_val({nm, "_result"}, {32'h0, resp_result}, {32'h0, e.res});
        check_val({nm, "_tag"}, {59'h0, resp_tag}, {59'h0, e.tag});
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                req_valid = 1'b1; req_op = 3'd0; req_a = 32'h3; req_b = 32'h5; req_tag = 5'd9;
            end
            @(posedge clk);
            #1;
            check_val({nm, "_hold_valid"}, {63'h0, resp_valid}, 64'h1);
            check_val({nm, "_hold_result"}, {32'h0, resp_result}, {32'h0, e.res});
            check_val({nm, "_hold_tag"}, {59'h0, resp_tag}, {59'h0, e.tag});
            check_val({nm, "_hold_req_ready"}, {63'h0, req_ready}, 64'h0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_val({nm, "_post_valid"}, {63'h0, resp_valid}, 64'h0);
        check_val({nm, "_post_ready"}, {63'h0, req_ready}, 64'h1);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          seen;
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 3'd0; req_a = 32'h0; req_b = 32'h0; req_tag = 5'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check_val("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        check_val("rst_busy", {63'h0, busy}, 64'h0);
        check_val("rst_result", {32'h0, resp_result}, 64'h0);
        check_val("rst_tag", {59'h0, resp_tag}, 64'h0);
        reset = 1'b0;

        // Multiply cases
        do_op("mul_7x-3",  3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 0);
        do_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 0);
        do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 0);
        do_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 0);
        do_op("mul_6x7",   3'd0, 32'd6,         32'd7,         5'd7,  32'd42,        0);
        // Divide cases
        do_op("div_-7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 0);
        do_op("rem_-7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 0);
        do_op("divu_100",  3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        0);
        do_op("remu_100",  3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         0);
        // Early-out boundary cases
        do_op("divu_by0",  3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 0);
        do_op("rem_by0",   3'd6, 32'd5,         32'd0,         5'd14, 32'd5,         0);
        do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
        do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0);
        // Back-pressure: result held for 10 cycles, stray request ignored
        do_op("hold_divu", 3'd5, 32'd1000,      32'd9,         5'd17, 32'd111,       10);

        // Random ops checked against the reference model
        for (int k = 0; k < 16; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (k % 5 == 4) ? 32'h0 : $urandom;
            if (k % 3 == 1) rb = rb >> $urandom_range(8, 30);
            do_op("rand", rop, ra, rb, 5'(k), ref_op(rop, ra, rb), 0);
        end

        // Flush at cycle 15 of a DIV: no response must follow
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_val("flush_busy", {63'h0, busy}, 64'h0);
        check_val("flush_valid", {63'h0, resp_valid}, 64'h0);
        check_val("flush_req_ready", {63'h0, req_ready}, 64'h1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check_val("flush_no_resp", {63'h0, seen}, 64'h0);
        do_op("after_flush", 3'd5, 32'd50, 32'd6, 5'd21, 32'd8, 0);

        // Synchronous reset in the middle of an operation
        @(negedge clk);
`ifdef RISCV_MULDIV_FAST_MUL_EN
        req_op = 3'd4;
`else
        req_op = 3'd0;
`endif
        req_valid = 1'b1; req_a = 32'd123; req_b = 32'd45; req_tag = 5'd22;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("mid_rst_req_ready", {63'h0, req_ready}, 64'h1);
        check_val("mid_rst_valid", {63'h0, resp_valid}, 64'h0);
        check_val("mid_rst_busy", {63'h0, busy}, 64'h0);
        check_val("mid_rst_result", {32'h0, resp_result}, 64'h0);
        check_val("mid_rst_tag", {59'h0, resp_tag}, 64'h0);
        do_op("after_rst", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23, 32'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
